// File: rtl/ifetch_pipe.sv
// ---------------------------------------------------------------------------
// ifetch_pipe
//
// Pipelined instruction-fetch stage. Holds the fetch PC, issues one word read
// per cycle to a synchronous instruction ROM (1-cycle read latency), buffers
// returned words in a DEPTH-entry prefetch FIFO and hands them to decode over
// a valid/ready handshake. Jump / jal / jr / branch redirects flush the
// buffer and discard the response that is still in flight.
//
// Parameters
//   XLEN      PC / instruction / target width
//   IMEM_AW   ROM word-address width
//   DEPTH     prefetch FIFO entries (>= 2 for one instruction per cycle)
//   RESET_PC  PC after reset (multiple of 4)
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           synchronous reset, active low
//   en            global enable; low freezes issue, pop and redirect
//   Jmp/Jal/Jr/Branch        redirect requests (qualified by en)
//   Addr_Jmp/Addr_Jr/Addr_Beq redirect targets, bits [1:0] ignored
//   imem_en       ROM read strobe
//   imem_addr     ROM word address, pc[IMEM_AW+1:2]
//   imem_rdata    ROM data, valid the cycle after imem_en
//   if_valid      head FIFO entry available to decode
//   id_ready      decode accepts the head entry
//   Instruction   head instruction
//   if_pc         PC of the head instruction
//   PC_plus_4     if_pc + 4 (wraps)
// ---------------------------------------------------------------------------
module ifetch_pipe #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 10,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Branch,
  input  logic [XLEN-1:0]    Addr_Jmp,
  input  logic [XLEN-1:0]    Addr_Jr,
  input  logic [XLEN-1:0]    Addr_Beq,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    Instruction,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    PC_plus_4
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // Fetch state
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_pc_q;
  logic            inflight_q;
  logic            kill_q;

  // Prefetch FIFO
  logic [XLEN-1:0] fifo_pc_q  [DEPTH];
  logic [XLEN-1:0] fifo_ins_q [DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q, count_d;

  // Last presented head, shown while the FIFO is empty
  logic [XLEN-1:0] hold_pc_q, hold_ins_q;

  logic            run;
  logic            redir;
  logic            pop;
  logic            push;
  logic            issue;
  logic [XLEN-1:0] target;
  logic [CW1-1:0]  occupancy;
  logic [XLEN-1:0] head_pc, head_ins;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset gates the handshake so nothing is issued or handed over while it
  // is asserted.
  assign run   = en & rst;
  assign redir = run & (Jmp | Jal | Jr | Branch);

  always_comb begin
    target = Addr_Beq;
    if (Jal | Jmp)   target = Addr_Jmp;
    else if (Jr)     target = Addr_Jr;
  end

  // During a redirect the head entry is wrong-path and is never handed over.
  assign if_valid = rst & (count_q != '0) & ~redir;
  assign pop      = if_valid & id_ready & en;

  // Slots already owned by the FIFO plus the response in flight, minus the
  // one leaving this cycle; a new read is only issued if its word will fit.
  assign occupancy = {1'b0, count_q} + CW1'(inflight_q) - CW1'(pop);
  assign issue     = run & ~redir & (occupancy < CW1'(DEPTH));

  // A response landing in the redirect cycle itself is stale as well; the
  // flush wins over the push.
  assign push = rst & inflight_q & ~kill_q & ~redir;

  assign imem_en   = issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  always_comb begin
    pc_d = pc_q;
    if (redir)      pc_d = target & ALIGN_MASK;
    else if (issue) pc_d = pc_q + XLEN'(4);
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      hold_pc_q  <= '0;
      hold_ins_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      kill_q     <= redir & inflight_q;
      if (issue) tag_pc_q <= pc_q;
      hold_pc_q  <= head_pc;
      hold_ins_q <= head_ins;
      if (redir) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_q <= ptr_inc(wr_q);
        if (pop)  rd_q <= ptr_inc(rd_q);
      end
    end
  end

  // FIFO payload needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_q]  <= tag_pc_q;
      fifo_ins_q[wr_q] <= imem_rdata;
    end
  end

  always_comb begin
    head_pc  = hold_pc_q;
    head_ins = hold_ins_q;
    if (count_q != '0) begin
      head_pc  = fifo_pc_q[rd_q];
      head_ins = fifo_ins_q[rd_q];
    end
  end

  assign Instruction = head_ins;
  assign if_pc       = head_pc;
  assign PC_plus_4   = head_pc + XLEN'(4);

endmodule

// File: tb/tb_ifetch_pipe.sv
module tb_ifetch_pipe;

  logic        clk = 1'b0;
  logic        rst, en, id_ready;
  logic        Jmp, Jal, Jr, Branch;
  logic [31:0] Addr_Jmp, Addr_Jr, Addr_Beq;
  logic        imem_en, if_valid;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, Instruction, if_pc, PC_plus_4;

  // Second instance for PC wrap / address aliasing
  logic        w_en = 1'b1, w_ready = 1'b1, w_zero = 1'b0;
  logic [31:0] w_addr0 = 32'h0;
  logic        w_imem_en, w_if_valid;
  logic [9:0]  w_imem_addr;
  logic [31:0] w_imem_rdata, w_Instruction, w_if_pc, w_PC_plus_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_pipe #(.XLEN(32), .IMEM_AW(10), .DEPTH(2), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Branch(Branch),
    .Addr_Jmp(Addr_Jmp), .Addr_Jr(Addr_Jr), .Addr_Beq(Addr_Beq),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .id_ready(id_ready),
    .Instruction(Instruction), .if_pc(if_pc), .PC_plus_4(PC_plus_4)
  );

  ifetch_pipe #(.XLEN(32), .IMEM_AW(10), .DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .en(w_en),
    .Jmp(w_zero), .Jal(w_zero), .Jr(w_zero), .Branch(w_zero),
    .Addr_Jmp(w_addr0), .Addr_Jr(w_addr0), .Addr_Beq(w_addr0),
    .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .if_valid(w_if_valid), .id_ready(w_ready),
    .Instruction(w_Instruction), .if_pc(w_if_pc), .PC_plus_4(w_PC_plus_4)
  );

  // ROM models: each word holds its own byte address.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= {20'h0, imem_addr, 2'b00};
    if (w_imem_en) w_imem_rdata <= {20'h0, w_imem_addr, 2'b00};
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic head_chk(input string tag, input bit v, input logic [31:0] pc);
    check_eq({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      check_eq({tag, ".pc"},  if_pc,       pc);
      check_eq({tag, ".ins"}, Instruction, pc);
      check_eq({tag, ".p4"},  PC_plus_4,   pc + 32'd4);
    end
  endtask

  task automatic issue_chk(input string tag, input bit e, input logic [9:0] a);
    check_eq({tag, ".imem_en"}, {31'b0, imem_en}, {31'b0, e});
    if (e) check_eq({tag, ".imem_addr"}, {22'b0, imem_addr}, {22'b0, a});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; id_ready = 1'b1;
    Jmp = 1'b0; Jal = 1'b0; Jr = 1'b0; Branch = 1'b0;
    Addr_Jmp = '0; Addr_Jr = '0; Addr_Beq = '0;
    #2;
    check_eq("rst.imem_en", {31'b0, imem_en}, 32'd0);
    adv(); adv();

    // c0: reset values, first issue
    rst = 1'b1; #1;
    check_eq("c0.valid", {31'b0, if_valid}, 32'd0);
    check_eq("c0.ins",   Instruction, 32'h0);
    check_eq("c0.pc",    if_pc,       32'h0);
    check_eq("c0.p4",    PC_plus_4,   32'h4);
    issue_chk("c0", 1'b1, 10'h000);
    check_eq("w0.imem_addr", {22'b0, w_imem_addr}, 32'h3FF);
    // c1
    adv(); #1;
    head_chk("c1", 1'b0, 32'h0);
    issue_chk("c1", 1'b1, 10'h001);
    check_eq("w1.imem_addr", {22'b0, w_imem_addr}, 32'h000);
    check_eq("w1.imem_en",   {31'b0, w_imem_en},   32'd1);
    // c2..c5: one instruction per cycle
    for (int k = 2; k <= 5; k++) begin
      adv(); #1;
      head_chk($sformatf("c%0d", k), 1'b1, 32'(4 * (k - 2)));
      if (k == 2) begin
        check_eq("w2.pc",  w_if_pc,       32'hFFFF_FFFC);
        check_eq("w2.p4",  w_PC_plus_4,   32'h0);
        check_eq("w2.ins", w_Instruction, 32'h0000_0FFC);
      end
      if (k == 3) begin
        check_eq("w3.pc", w_if_pc,     32'h0);
        check_eq("w3.p4", w_PC_plus_4, 32'h4);
      end
    end

    // c6..c10: backpressure, FIFO fills and issue stops
    for (int k = 6; k <= 10; k++) begin
      adv(); id_ready = 1'b0; #1;
      head_chk($sformatf("bp%0d", k), 1'b1, 32'h10);
      issue_chk($sformatf("bp%0d", k), 1'b0, 10'h0);
    end
    // c11..c14: resume without gaps or repeats
    adv(); id_ready = 1'b1; #1;
    head_chk("c11", 1'b1, 32'h10);
    issue_chk("c11", 1'b1, 10'h006);
    for (int k = 12; k <= 14; k++) begin
      adv(); #1;
      head_chk($sformatf("c%0d", k), 1'b1, 32'(32'h10 + 4 * (k - 11)));
    end

    // c15: redirect with all sources, Jmp target must win
    adv();
    Jmp = 1'b1; Jr = 1'b1; Branch = 1'b1;
    Addr_Jmp = 32'h100; Addr_Jr = 32'h200; Addr_Beq = 32'h300;
    #1;
    head_chk("R", 1'b0, 32'h0);
    issue_chk("R", 1'b0, 10'h0);
    adv(); Jmp = 1'b0; Jr = 1'b0; Branch = 1'b0; #1;
    head_chk("R+1", 1'b0, 32'h0);
    issue_chk("R+1", 1'b1, 10'h040);
    adv(); #1;
    head_chk("R+2", 1'b0, 32'h0);
    adv(); #1;
    head_chk("R+3", 1'b1, 32'h100);
    adv(); #1;
    head_chk("R+4", 1'b1, 32'h104);

    // c20..c23: en low with a branch request; response still lands
    for (int k = 20; k <= 23; k++) begin
      adv(); en = 1'b0; Branch = 1'b1; #1;
      head_chk($sformatf("en%0d", k), 1'b1, 32'h108);
      issue_chk($sformatf("en%0d", k), 1'b0, 10'h0);
    end
    check_eq("en23.imem_addr", {22'b0, imem_addr}, 32'h044);
    adv(); en = 1'b1; Branch = 1'b0; #1;
    head_chk("c24", 1'b1, 32'h108);
    issue_chk("c24", 1'b1, 10'h044);
    adv(); #1;
    head_chk("c25", 1'b1, 32'h10C);
    adv(); #1;
    head_chk("c26", 1'b1, 32'h110);
    adv(); #1;

    // c28: reset during a redirect
    adv(); rst = 1'b0; Jmp = 1'b1; Addr_Jmp = 32'h200; #1;
    check_eq("rst2.imem_en", {31'b0, imem_en}, 32'd0);
    adv(); rst = 1'b1; Jmp = 1'b0; #1;
    check_eq("rst2.valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst2.ins",   Instruction, 32'h0);
    check_eq("rst2.pc",    if_pc,       32'h0);
    check_eq("rst2.p4",    PC_plus_4,   32'h4);
    issue_chk("rst2", 1'b1, 10'h000);
    adv(); #1;
    head_chk("rst2+1", 1'b0, 32'h0);
    adv(); #1;
    head_chk("rst2+2", 1'b1, 32'h0);
    adv(); #1;
    head_chk("rst2+3", 1'b1, 32'h4);

    // Back-to-back redirects: second target wins
    adv(); Jmp = 1'b1; Addr_Jmp = 32'h40; #1;
    head_chk("bb0", 1'b0, 32'h0);
    issue_chk("bb0", 1'b0, 10'h0);
    adv(); Jmp = 1'b0; Jr = 1'b1; Addr_Jr = 32'h83; #1;
    head_chk("bb1", 1'b0, 32'h0);
    issue_chk("bb1", 1'b0, 10'h0);
    adv(); Jr = 1'b0; #1;
    head_chk("bb2", 1'b0, 32'h0);
    issue_chk("bb2", 1'b1, 10'h020);
    adv(); #1;
    head_chk("bb3", 1'b0, 32'h0);
    adv(); #1;
    head_chk("bb4", 1'b1, 32'h80);
    adv(); #1;
    head_chk("bb5", 1'b1, 32'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
